axis_frame_receiver: RTL and testbench
======================================

# axis_frame_receiver

AXI4-Stream video sink and frame checker that terminates the pixel stream produced by the fractal generators. It accepts 32-bit RGB beats framed by tuser (start of frame) and tlast (end of frame) and tracks raster position. It validates framing against the configured resolution, presents each accepted pixel with its coordinates, and reports per-frame checksums, frame counts and framing errors. It sits at the consumer end of the generator stream, in place of the display/simulator sink.

## Interface
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- XW, 10, width of x coordinate
- YW, 9, width of y coordinate
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- in_stream_tdata  in  32  R=[31:24], G=[23:16], B=[15:8], [7:0] ignored
- in_stream_tkeep  in  4  byte enables; 4'hF required
- in_stream_tlast  in  1  last pixel of frame
- in_stream_tuser  in  1  first pixel of frame
- in_stream_tvalid  in  1  beat valid
- in_stream_tready  out  1  beat accepted when tvalid & tready
- stall_i  in  1  request backpressure
- err_clr_i  in  1  clear err_flags and err_count
- pix_valid  out  1  one-cycle pixel strobe
- pix_x / pix_y  out  XW / YW  coordinates of presented pixel
- pix_r / pix_g / pix_b  out  8 each  pixel colour
- frame_done  out  1  one-cycle pulse on a correctly terminated frame
- frame_sum  out  32  checksum of the last completed frame
- frame_count  out  16  completed frames, wraps
- err_count  out  16  beats with at least one error, saturates at 16'hFFFF
- err_flags  out  4  sticky: [0] early_sof, [1] early_last, [2] missing_last, [3] bad_keep

## Operation
- The block uses two states, HUNT and RECV. Reset state is HUNT.
- HUNT: accepted beats with tuser=0 are discarded with no pix_valid and no error. A beat with tuser=1 is the pixel at (0,0) and moves the block to RECV.
- RECV: each accepted beat is the pixel at the current (x,y). x advances and wraps at X_SIZE-1, at which point y advances.
- Beat checks in RECV, evaluated in this order:
  - tuser=1 at a position other than (0,0) sets early_sof. The frame restarts and the beat is taken as (0,0).
  - tlast=1 at a position other than (X_SIZE-1, Y_SIZE-1) sets early_last. The pixel is presented and the block returns to HUNT.
  - At the last position with tlast=0, missing_last is set. The pixel is presented and the block returns to HUNT.
  - At the last position with tlast=1, the frame completes: frame_done pulses and the block returns to HUNT.
  - tkeep != 4'hF sets bad_keep. The pixel is still processed normally.
- Checksum: a 32-bit accumulator adds the zero-extended {r,g,b} of every presented pixel, mod 2^32. It is reset on each (0,0) pixel.
- Checksum publication: on a completed frame, frame_sum is loaded with the accumulated value including the last pixel, and frame_count increments.
- Frames ending in an error do not update frame_sum or frame_count.
- err_count increments by 1 per beat carrying any error.
- err_clr_i has priority over existing flags and count. If a new error occurs in the same cycle as err_clr_i, err_flags holds only the new bits and err_count = 1.

## Timing
- in_stream_tready is registered as ~stall_i, so a change on stall_i reaches tready one cycle later. Reset value 0; first possible assertion is the first aclk edge after reset release.
- Handshake on edge N causes pix_valid, pix_x/y and pix_r/g/b to be valid in cycle N+1, with pix_valid high for exactly one cycle.
- frame_done, frame_sum and frame_count update in the same cycle as the pix_valid of the last pixel.
- Beats with tvalid=0 or tready=0 leave all state unchanged.
- Reset values: all outputs 0 and the state is HUNT.
- Asynchronous reset mid-frame discards the partial frame and clears the checksum accumulator, counters and flags.

## Structure
- Shared package holds:
  - X_SIZE/Y_SIZE defaults
  - the ERR_EARLY_SOF, ERR_EARLY_LAST, ERR_MISSING_LAST and ERR_BAD_KEEP bit indices
  - the HUNT/RECV state enum
- One sub-module, frame_position_counter, holds the x/y raster counter with a restart-to-(0,0) input and an at_last output. The top level holds the FSM, checks, checksum and output registers.

## Test plan
- Clean 640x480 frame, constant tdata 32'h10203000, tuser on the first beat, tlast on the last → 307200 pix_valid, one frame_done, frame_sum 32'h96E10000, frame_count 1, err_flags 0.
- Three idle beats with tuser=0 before a frame (X_SIZE=8, Y_SIZE=4) → no pix_valid for the idle beats, then 32 pixels, frame_count 1.
- X_SIZE=8, Y_SIZE=4, tlast on beat 10 → err_flags 4'b0010, err_count 1, no frame_done, HUNT until the next tuser.
- X_SIZE=8, Y_SIZE=4, tuser again on beat 5 → err_flags[0] set, that beat presented at (0,0), and a full 32-pixel frame then completes with frame_done.
- stall_i toggling every 3 cycles plus tvalid gaps through a clean frame → pixel sequence and frame_sum identical to the unstalled run; tready lags stall_i by 1 cycle.
- aresetn pulsed at pixel (3,1), then a clean frame → all outputs 0 during reset; the next frame completes with frame_count 1 and the correct frame_sum.

Source files
------------

// File: rtl/axis_frame_receiver_pkg.sv
// Shared definitions for the AXI4-Stream frame receiver: default raster size,
// error flag bit positions, receiver states and the checksum pixel helper.
package axis_frame_receiver_pkg;

  localparam int X_SIZE_DEFAULT = 640;
  localparam int Y_SIZE_DEFAULT = 480;

  localparam int ERR_W            = 4;
  localparam int ERR_EARLY_SOF    = 0;
  localparam int ERR_EARLY_LAST   = 1;
  localparam int ERR_MISSING_LAST = 2;
  localparam int ERR_BAD_KEEP     = 3;

  typedef logic [0:0] rx_state_t;
  localparam rx_state_t HUNT = 1'b0;
  localparam rx_state_t RECV = 1'b1;

  function automatic logic [31:0] pixel_word(input logic [23:0] rgb);
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/axis_frame_receiver_frame_position_counter.sv
// Raster x/y counter for the frame receiver; restart forces the current beat to
// (0,0) before any advance is applied.
module frame_position_counter
  import axis_frame_receiver_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEFAULT,
  parameter int Y_SIZE = Y_SIZE_DEFAULT,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          restart,
  input  logic          advance,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          at_origin,
  output logic          at_last
);

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 32'sd1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 32'sd1);
  localparam logic [XW-1:0] X_ONE  = XW'(32'd1);
  localparam logic [YW-1:0] Y_ONE  = YW'(32'd1);

  logic [XW-1:0] pos_x_r, base_x_s, next_x_s;
  logic [YW-1:0] pos_y_r, base_y_s, next_y_s;

  // Next raster position from the (possibly restarted) current position
  always_comb begin
    base_x_s = restart ? {XW{1'b0}} : pos_x_r;
    base_y_s = restart ? {YW{1'b0}} : pos_y_r;
    next_x_s = base_x_s;
    next_y_s = base_y_s;
    if (advance) begin
      if (base_x_s == X_LAST) begin
        next_x_s = {XW{1'b0}};
        if (base_y_s == Y_LAST) begin
          next_y_s = {YW{1'b0}};
        end else begin
          next_y_s = base_y_s + Y_ONE;
        end
      end else begin
        next_x_s = base_x_s + X_ONE;
        next_y_s = base_y_s;
      end
    end else begin
      next_x_s = base_x_s;
      next_y_s = base_y_s;
    end
  end

  // Position register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pos_x_r <= {XW{1'b0}};
      pos_y_r <= {YW{1'b0}};
    end else begin
      pos_x_r <= next_x_s;
      pos_y_r <= next_y_s;
    end
  end

  assign pos_x     = pos_x_r;
  assign pos_y     = pos_y_r;
  assign at_origin = (pos_x_r == {XW{1'b0}}) && (pos_y_r == {YW{1'b0}});
  assign at_last   = (pos_x_r == X_LAST) && (pos_y_r == Y_LAST);

endmodule

// File: rtl/axis_frame_receiver.sv
// AXI4-Stream video sink: checks tuser/tlast framing against the raster size,
// presents pixels with coordinates and reports checksums, frame and error counts.
module axis_frame_receiver
  import axis_frame_receiver_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEFAULT,
  parameter int Y_SIZE = Y_SIZE_DEFAULT,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [31:0]   in_stream_tdata,
  input  logic [3:0]    in_stream_tkeep,
  input  logic          in_stream_tlast,
  input  logic          in_stream_tuser,
  input  logic          in_stream_tvalid,
  output logic          in_stream_tready,
  input  logic          stall_i,
  input  logic          err_clr_i,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic          frame_done,
  output logic [31:0]   frame_sum,
  output logic [15:0]   frame_count,
  output logic [15:0]   err_count,
  output logic [3:0]    err_flags
);

  localparam logic ORIGIN_IS_LAST = (X_SIZE == 32'sd1) && (Y_SIZE == 32'sd1);

  logic            tready_r;
  rx_state_t       state_r, state_next_s;
  logic            accept_s, sof_s, beat_s, beat_last_s, done_s, ends_s;
  logic [XW-1:0]   pos_x_s, beat_x_s;
  logic [YW-1:0]   pos_y_s, beat_y_s;
  logic            at_origin_s, at_last_s;
  logic [ERR_W-1:0] new_err_s, err_flags_next_s, err_flags_r;
  logic [15:0]     err_count_base_s, err_count_next_s, err_count_r;
  logic [31:0]     acc_r, acc_base_s, acc_sum_s, frame_sum_r;
  logic [15:0]     frame_count_r;
  logic            pix_valid_r, frame_done_r;
  logic [XW-1:0]   pix_x_r;
  logic [YW-1:0]   pix_y_r;
  logic [7:0]      pix_r_r, pix_g_r, pix_b_r;
  logic            unused_s;

  assign unused_s = ^in_stream_tdata[7:0];

  frame_position_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE),
    .XW     (XW),
    .YW     (YW)
  ) u_pos (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .restart   (beat_s & sof_s),
    .advance   (beat_s),
    .pos_x     (pos_x_s),
    .pos_y     (pos_y_s),
    .at_origin (at_origin_s),
    .at_last   (at_last_s)
  );

  // Beat classification and framing checks; a tuser beat is always taken as (0,0)
  always_comb begin
    accept_s    = in_stream_tvalid & tready_r;
    sof_s       = in_stream_tuser;
    beat_s      = accept_s & ((state_r == RECV) | sof_s);
    beat_x_s    = sof_s ? {XW{1'b0}} : pos_x_s;
    beat_y_s    = sof_s ? {YW{1'b0}} : pos_y_s;
    beat_last_s = sof_s ? ORIGIN_IS_LAST : at_last_s;
    ends_s      = in_stream_tlast | beat_last_s;
    new_err_s   = {ERR_W{1'b0}};
    done_s      = 1'b0;
    if (beat_s) begin
      new_err_s[ERR_EARLY_SOF]    = (state_r == RECV) & sof_s & ~at_origin_s;
      new_err_s[ERR_EARLY_LAST]   = in_stream_tlast & ~beat_last_s;
      new_err_s[ERR_MISSING_LAST] = beat_last_s & ~in_stream_tlast;
      new_err_s[ERR_BAD_KEEP]     = (in_stream_tkeep != 4'hF);
      done_s                      = beat_last_s & in_stream_tlast;
    end else begin
      new_err_s = {ERR_W{1'b0}};
      done_s    = 1'b0;
    end
  end

  // Next receiver state: any frame termination, good or bad, returns to HUNT
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HUNT: begin
        if (beat_s) begin
          state_next_s = ends_s ? HUNT : RECV;
        end else begin
          state_next_s = HUNT;
        end
      end
      RECV: begin
        if (beat_s) begin
          state_next_s = ends_s ? HUNT : RECV;
        end else begin
          state_next_s = RECV;
        end
      end
      default: state_next_s = HUNT;
    endcase
  end

  // Checksum and error bookkeeping; err_clr_i drops old history but keeps new errors
  always_comb begin
    acc_base_s       = sof_s ? 32'h0000_0000 : acc_r;
    acc_sum_s        = acc_base_s + pixel_word(in_stream_tdata[31:8]);
    err_flags_next_s = (err_clr_i ? {ERR_W{1'b0}} : err_flags_r) | new_err_s;
    err_count_base_s = err_clr_i ? 16'h0000 : err_count_r;
    if (|new_err_s) begin
      if (err_count_base_s == 16'hFFFF) begin
        err_count_next_s = err_count_base_s;
      end else begin
        err_count_next_s = err_count_base_s + 16'h0001;
      end
    end else begin
      err_count_next_s = err_count_base_s;
    end
  end

  // Ready is a registered copy of the inverted stall request
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tready_r <= 1'b0;
    end else begin
      tready_r <= ~stall_i;
    end
  end

  // FSM state and running checksum
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= HUNT;
      acc_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      if (beat_s) begin
        acc_r <= acc_sum_s;
      end
    end
  end

  // Frame statistics, published only for correctly terminated frames
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_done_r  <= 1'b0;
      frame_sum_r   <= 32'h0000_0000;
      frame_count_r <= 16'h0000;
    end else begin
      frame_done_r <= done_s;
      if (done_s) begin
        frame_sum_r   <= acc_sum_s;
        frame_count_r <= frame_count_r + 16'h0001;
      end
    end
  end

  // Sticky error flags and saturating error count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_flags_r <= {ERR_W{1'b0}};
      err_count_r <= 16'h0000;
    end else begin
      err_flags_r <= err_flags_next_s;
      err_count_r <= err_count_next_s;
    end
  end

  // Presented pixel registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_valid_r <= 1'b0;
      pix_x_r     <= {XW{1'b0}};
      pix_y_r     <= {YW{1'b0}};
      pix_r_r     <= 8'h00;
      pix_g_r     <= 8'h00;
      pix_b_r     <= 8'h00;
    end else begin
      pix_valid_r <= beat_s;
      if (beat_s) begin
        pix_x_r <= beat_x_s;
        pix_y_r <= beat_y_s;
        pix_r_r <= in_stream_tdata[31:24];
        pix_g_r <= in_stream_tdata[23:16];
        pix_b_r <= in_stream_tdata[15:8];
      end
    end
  end

  assign in_stream_tready = tready_r;
  assign pix_valid        = pix_valid_r;
  assign pix_x            = pix_x_r;
  assign pix_y            = pix_y_r;
  assign pix_r            = pix_r_r;
  assign pix_g            = pix_g_r;
  assign pix_b            = pix_b_r;
  assign frame_done       = frame_done_r;
  assign frame_sum        = frame_sum_r;
  assign frame_count      = frame_count_r;
  assign err_count        = err_count_r;
  assign err_flags        = err_flags_r;

endmodule

// File: tb/tb_axis_frame_receiver.sv
// Directed bench for axis_frame_receiver: an 8x4 instance for framing, error,
// stall and reset scenarios and a 640-wide instance for a long clean frame.
module tb_axis_frame_receiver;

  localparam int XS = 8;
  localparam int NB = 640 * 60;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic        stall_i = 1'b0;
  logic        err_clr;
  logic        pix_valid, frame_done;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [31:0] frame_sum;
  logic [15:0] frame_count, err_count;
  logic [3:0]  err_flags;

  logic [31:0] tdata_b;
  logic        tlast_b, tuser_b, tvalid_b, tready_b;
  logic        pix_valid_b, frame_done_b;
  logic [9:0]  pix_x_b;
  logic [8:0]  pix_y_b;
  logic [7:0]  pix_r_b, pix_g_b, pix_b_b;
  logic [31:0] frame_sum_b;
  logic [15:0] frame_count_b, err_count_b;
  logic [3:0]  err_flags_b;

  axis_frame_receiver #(.X_SIZE(8), .Y_SIZE(4), .XW(10), .YW(9)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .stall_i(stall_i), .err_clr_i(err_clr),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_count(frame_count),
    .err_count(err_count), .err_flags(err_flags)
  );

  axis_frame_receiver #(.X_SIZE(640), .Y_SIZE(60), .XW(10), .YW(9)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(tdata_b), .in_stream_tkeep(4'hF), .in_stream_tlast(tlast_b),
    .in_stream_tuser(tuser_b), .in_stream_tvalid(tvalid_b), .in_stream_tready(tready_b),
    .stall_i(1'b0), .err_clr_i(1'b0),
    .pix_valid(pix_valid_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .pix_r(pix_r_b), .pix_g(pix_g_b), .pix_b(pix_b_b),
    .frame_done(frame_done_b), .frame_sum(frame_sum_b), .frame_count(frame_count_b),
    .err_count(err_count_b), .err_flags(err_flags_b)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
  } pix_t;

  typedef struct {
    int          pre;
    int          n;
    int          sof2;
    int          last_at;
    int          keep_at;
    int          trail;
    int          exp_pix;
    logic        exp_done;
    logic [3:0]  exp_flags;
    logic [15:0] exp_ec;
  } row_t;

  int          checks = 0;
  int          failures = 0;
  pix_t        got_q[$];
  int          done_cnt = 0;
  int          pixb_cnt = 0;
  int          doneb_cnt = 0;
  logic [9:0]  lastx_b;
  logic [8:0]  lasty_b;
  logic [31:0] exp_sum = 32'h0;
  int          exp_fc = 0;
  logic        stall_run = 1'b0;
  logic        lag_chk = 1'b0;
  logic        stall_q = 1'b0;
  int          ph = 0;
  row_t        rows[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {k * 8'd3 + 8'd1, k + 8'd7, k ^ 8'h5A, 8'hEE};
  endfunction

  // Pixel and frame_done monitors, sampled away from the active edge
  always @(negedge aclk) begin
    if (pix_valid) got_q.push_back({pix_x, pix_y, pix_r, pix_g, pix_b});
    if (frame_done) done_cnt++;
    if (pix_valid_b) begin
      pixb_cnt++;
      lastx_b = pix_x_b;
      lasty_b = pix_y_b;
    end
    if (frame_done_b) doneb_cnt++;
  end

  // Stall generator: toggles every 3 cycles while enabled
  always @(negedge aclk) begin
    if (stall_run) begin
      ph++;
      if (ph == 3) begin
        ph = 0;
        stall_i = ~stall_i;
      end
    end else begin
      ph = 0;
      stall_i = 1'b0;
    end
  end

  always @(posedge aclk) stall_q <= stall_i;

  always @(negedge aclk) begin
    if (lag_chk) chk("tready_lag", tready, !stall_q);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic send(input logic [31:0] d, input logic u, input logic l, input logic [3:0] k);
    int n;
    tdata = d; tuser = u; tlast = l; tkeep = k; tvalid = 1'b1;
    n = 0;
    while (tready !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
    @(negedge aclk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tready"}, tready, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_xy"}, {pix_x, pix_y}, 0);
    chk({tag, "_pix_rgb"}, {pix_r, pix_g, pix_b}, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_sum"}, frame_sum, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_err_flags"}, err_flags, 0);
  endtask

  task automatic run_row(input row_t r, input int gap);
    int base, d0, n_got;
    logic [31:0] p, s;
    pix_t e;
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    got_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < r.pre; i++) send(pat(100 + i), 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < r.n; k++) begin
      send(pat(k), (k == 0) || (k == r.sof2), k == r.last_at, (k == r.keep_at) ? 4'h7 : 4'hF);
      if (gap > 0 && (k % gap) == 2) idle(2);
    end
    for (int i = 0; i < r.trail; i++) send(pat(200 + i), 1'b0, 1'b0, 4'hF);
    idle(4);
    chk("pix_count", got_q.size(), r.exp_pix);
    n_got = (got_q.size() < r.exp_pix) ? got_q.size() : r.exp_pix;
    for (int j = 0; j < n_got; j++) begin
      base = (r.sof2 >= 0 && j >= r.sof2) ? r.sof2 : 0;
      p = pat(j);
      e.x = 10'((j - base) % XS);
      e.y = 9'((j - base) / XS);
      e.rgb = p[31:8];
      chk("pixel", got_q[j], e);
    end
    if (r.exp_done) begin
      s = 32'h0;
      base = (r.sof2 >= 0) ? r.sof2 : 0;
      for (int j = base; j < r.n; j++) begin
        p = pat(j);
        s = s + {8'h00, p[31:8]};
      end
      exp_sum = s;
      exp_fc++;
    end
    chk("frame_done_pulses", done_cnt - d0, r.exp_done);
    chk("frame_count", frame_count, exp_fc);
    chk("frame_sum", frame_sum, exp_sum);
    chk("err_flags", err_flags, r.exp_flags);
    chk("err_count", err_count, r.exp_ec);
  endtask

  initial begin
    rows[0] = '{pre:0, n:32, sof2:-1, last_at:31, keep_at:-1, trail:0, exp_pix:32,
                exp_done:1'b1, exp_flags:4'b0000, exp_ec:16'd0};
    rows[1] = '{pre:3, n:32, sof2:-1, last_at:31, keep_at:-1, trail:0, exp_pix:32,
                exp_done:1'b1, exp_flags:4'b0000, exp_ec:16'd0};
    rows[2] = '{pre:0, n:11, sof2:-1, last_at:10, keep_at:-1, trail:3, exp_pix:11,
                exp_done:1'b0, exp_flags:4'b0010, exp_ec:16'd1};
    rows[3] = '{pre:0, n:37, sof2:5, last_at:36, keep_at:-1, trail:0, exp_pix:37,
                exp_done:1'b1, exp_flags:4'b0001, exp_ec:16'd1};
    rows[4] = '{pre:0, n:32, sof2:-1, last_at:-1, keep_at:-1, trail:2, exp_pix:32,
                exp_done:1'b0, exp_flags:4'b0100, exp_ec:16'd1};
    rows[5] = '{pre:0, n:32, sof2:-1, last_at:31, keep_at:7, trail:0, exp_pix:32,
                exp_done:1'b1, exp_flags:4'b1000, exp_ec:16'd1};

    aresetn = 1'b0;
    tdata = 32'h0; tkeep = 4'h0; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b0; err_clr = 1'b0;
    tdata_b = 32'h0; tlast_b = 1'b0; tuser_b = 1'b0; tvalid_b = 1'b0;
    idle(3);
    check_zero("reset");
    aresetn = 1'b1;
    idle(2);
    chk("tready_after_reset", tready, 1);

    for (int r = 0; r < 6; r++) run_row(rows[r], 0);

    // err_clr in the same cycle as a new error keeps only the new error
    got_q.delete();
    send(pat(0), 1'b1, 1'b0, 4'hF);
    send(pat(1), 1'b0, 1'b0, 4'hF);
    err_clr = 1'b1;
    send(pat(2), 1'b0, 1'b1, 4'hF);
    err_clr = 1'b0;
    idle(3);
    chk("clr_same_cycle_flags", err_flags, 4'b0010);
    chk("clr_same_cycle_count", err_count, 1);
    chk("clr_same_cycle_pix", got_q.size(), 3);
    chk("clr_same_cycle_fc", frame_count, exp_fc);
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    chk("clr_flags", err_flags, 0);
    chk("clr_count", err_count, 0);

    // Backpressure and tvalid gaps through a clean frame
    stall_run = 1'b1;
    lag_chk = 1'b1;
    run_row(rows[0], 5);
    stall_run = 1'b0;
    idle(2);
    lag_chk = 1'b0;

    // Asynchronous reset at pixel (3,1), then a clean frame
    for (int k = 0; k < 12; k++) send(pat(k), k == 0, 1'b0, 4'hF);
    aresetn = 1'b0;
    #1;
    check_zero("midreset");
    idle(2);
    check_zero("midreset_hold");
    aresetn = 1'b1;
    exp_fc = 0;
    exp_sum = 32'h0;
    idle(2);
    run_row(rows[0], 0);

    // Long clean frame on the 640-wide instance
    begin
      int n;
      n = 0;
      while (tready_b !== 1'b1 && n < 100) begin
        @(negedge aclk);
        n++;
      end
      chk("b_tready", tready_b, 1);
      for (int i = 0; i < NB; i++) begin
        tdata_b = 32'h10203000;
        tuser_b = (i == 0);
        tlast_b = (i == NB - 1);
        tvalid_b = 1'b1;
        @(negedge aclk);
      end
      tvalid_b = 1'b0; tuser_b = 1'b0; tlast_b = 1'b0;
      idle(4);
      chk("b_pix_count", pixb_cnt, NB);
      chk("b_last_xy", {lastx_b, lasty_b}, {10'd639, 9'd59});
      chk("b_frame_done", doneb_cnt, 1);
      chk("b_frame_count", frame_count_b, 1);
      chk("b_frame_sum", frame_sum_b, 32'h72DC2000);
      chk("b_err_flags", err_flags_b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
